// File: rtl/cr16_pkg.sv
// CR16 control shared definitions: opcodes, ALU classes,
// branch conditions, sequencer states and decode bundle.
package cr16_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int EXT_HI = 7;
  localparam int EXT_LO = 4;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_LDST  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_IMM,
    CL_CMP,
    CL_LOAD,
    CL_STOR,
    CL_BR,
    CL_ILL
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] aluop;
    logic       imm_sel;
  } dec_t;

endpackage

// File: rtl/cr16_decode.sv
// CR16 instruction classifier: maps opcode/ext fields to an
// instruction class, ALU operation class and immediate select.
module cr16_decode
  import cr16_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [3:0] i_ext,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '{cls: CL_ILL, aluop: ALU_RTYPE, imm_sel: 1'b0};
    unique case (1'b1)
      i_op == OP_RTYPE: o_dec.cls = CL_ALU;
      i_op == OP_ADDI:  o_dec = '{CL_IMM, ALU_ADD, 1'b1};
      i_op == OP_SUBI:  o_dec = '{CL_IMM, ALU_SUB, 1'b1};
      i_op == OP_CMPI:  o_dec = '{CL_CMP, ALU_CMP, 1'b1};
      i_op == OP_ANDI:  o_dec = '{CL_IMM, ALU_AND, 1'b1};
      i_op == OP_ORI:   o_dec = '{CL_IMM, ALU_OR, 1'b1};
      i_op == OP_XORI:  o_dec = '{CL_IMM, ALU_XOR, 1'b1};
      i_op == OP_MOVI:  o_dec = '{CL_IMM, ALU_PASSB, 1'b1};
      i_op == OP_LDST && i_ext == EXT_LOAD:
        o_dec.cls = CL_LOAD;
      i_op == OP_LDST && i_ext == EXT_STOR:
        o_dec.cls = CL_STOR;
      i_op == OP_BCOND: o_dec.cls = CL_BR;
      default: ;
    endcase
  end

endmodule

// File: rtl/cr16_ctrl_fsm.sv
// CR16 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// req/ack memory handshake and branch condition evaluation.
module cr16_ctrl_fsm
  import cr16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          WIDTH    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] instr,
  input  logic             mem_ack,
  input  logic             flag_z,
  input  logic             flag_n,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic [15:0]      pc_init,
  output logic [2:0]       ALUop,
  output logic [3:0]       OPCodeExtention,
  output logic             imm_sel,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             flags_we,
  output logic             illegal
);

  state_t           r_state;
  logic [WIDTH-1:0] r_ir;
  dec_t             w_dec;
  logic             w_run;
  logic             w_taken;
  logic             w_alu;
  logic             w_fetch;
  logic             w_mem;
  logic             w_unused_rs;

  assign w_unused_rs = ^r_ir[3:0];

  cr16_decode u_dec (
    .i_op  (r_ir[OP_HI:OP_LO]),
    .i_ext (r_ir[EXT_HI:EXT_LO]),
    .o_dec (w_dec)
  );

  always_comb begin
    w_taken = 1'b0;
    unique case (r_ir[RD_HI:RD_LO])
      CC_EQ:   w_taken = flag_z;
      CC_NE:   w_taken = !flag_z;
      CC_LT:   w_taken = flag_n;
      CC_GE:   w_taken = !flag_n;
      CC_UC:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: if (mem_ack) begin
          r_ir    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          unique case (w_dec.cls)
            CL_LOAD, CL_STOR: r_state <= S_MEM;
            CL_ILL:           r_state <= S_FETCH;
            default:          r_state <= S_EXEC;
          endcase
        end
        S_EXEC: r_state <= S_FETCH;
        S_MEM: if (mem_ack) begin
          r_state <= (w_dec.cls == CL_STOR) ? S_FETCH : S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by reset_n so they read zero in every reset cycle.
  assign w_run   = reset_n;
  assign w_fetch = w_run && r_state == S_FETCH;
  assign w_mem   = w_run && r_state == S_MEM;
  assign w_alu   = w_run && r_state == S_EXEC &&
                   (w_dec.cls == CL_ALU || w_dec.cls == CL_IMM ||
                    w_dec.cls == CL_CMP);

  assign mem_req   = w_fetch || w_mem;
  assign mem_we    = w_mem && w_dec.cls == CL_STOR;
  assign addr_sel  = w_mem;
  assign ir_load   = w_fetch && mem_ack;
  assign pc_inc    = w_fetch && mem_ack;
  assign pc_branch = w_run && r_state == S_EXEC &&
                     w_dec.cls == CL_BR && w_taken;
  assign pc_init   = RESET_PC;

  assign ALUop           = w_run ? w_dec.aluop : ALU_RTYPE;
  assign OPCodeExtention = w_run ? r_ir[EXT_HI:EXT_LO] : 4'h0;
  assign imm_sel         = w_run && w_dec.imm_sel;

  assign reg_we   = (w_alu && w_dec.cls != CL_CMP) ||
                    (w_run && r_state == S_WB);
  assign wb_sel   = w_run && r_state == S_WB;
  assign flags_we = w_alu &&
                    (w_dec.cls == CL_ALU || w_dec.cls == CL_CMP ||
                     w_dec.aluop == ALU_ADD || w_dec.aluop == ALU_SUB);
  assign illegal  = w_run && r_state == S_DECODE &&
                    w_dec.cls == CL_ILL;

endmodule

// File: tb/tb_cr16_ctrl_fsm.sv
// Bench for cr16_ctrl_fsm: directed and random instruction streams
// checked cycle by cycle against a transaction-level reference.
module tb_cr16_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        mem_ack = 1'b0;
  logic        flag_z = 1'b0;
  logic        flag_n = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_inc;
  logic        pc_branch, imm_sel, reg_we, wb_sel, flags_we, illegal;
  logic [15:0] pc_init;
  logic [2:0]  ALUop;
  logic [3:0]  OPCodeExtention;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cr16_ctrl_fsm #(.RESET_PC(16'h0000), .WIDTH(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr           (instr),
    .mem_ack         (mem_ack),
    .flag_z          (flag_z),
    .flag_n          (flag_n),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .addr_sel        (addr_sel),
    .ir_load         (ir_load),
    .pc_inc          (pc_inc),
    .pc_branch       (pc_branch),
    .pc_init         (pc_init),
    .ALUop           (ALUop),
    .OPCodeExtention (OPCodeExtention),
    .imm_sel         (imm_sel),
    .reg_we          (reg_we),
    .wb_sel          (wb_sel),
    .flags_we        (flags_we),
    .illegal         (illegal)
  );

  // kind: 0 alu, 1 branch, 2 load, 3 stor, 4 illegal
  typedef struct packed {
    logic [2:0] kind;
    logic [2:0] alu;
    logic       imm;
    logic       fl;
    logic       rw;
  } ref_t;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ref_t ref_of(input logic [15:0] ir);
    ref_t r;
    r = '{3'd4, 3'd0, 1'b0, 1'b0, 1'b0};
    case (ir[15:12])
      4'h0: r = '{3'd0, 3'd0, 1'b0, 1'b1, 1'b1};
      4'h5: r = '{3'd0, 3'd1, 1'b1, 1'b1, 1'b1};
      4'h9: r = '{3'd0, 3'd2, 1'b1, 1'b1, 1'b1};
      4'hB: r = '{3'd0, 3'd7, 1'b1, 1'b1, 1'b0};
      4'h1: r = '{3'd0, 3'd3, 1'b1, 1'b0, 1'b1};
      4'h2: r = '{3'd0, 3'd4, 1'b1, 1'b0, 1'b1};
      4'h3: r = '{3'd0, 3'd5, 1'b1, 1'b0, 1'b1};
      4'hD: r = '{3'd0, 3'd6, 1'b1, 1'b0, 1'b1};
      4'hC: r.kind = 3'd1;
      4'h4: begin
        if (ir[7:4] == 4'h0) r.kind = 3'd2;
        else if (ir[7:4] == 4'h4) r.kind = 3'd3;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic taken(input logic [3:0] c, input logic z,
                                 input logic n);
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'hC: return n;
      4'hD: return !n;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [17:0] obs();
    return {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_branch,
            reg_we, wb_sel, flags_we, illegal,
            imm_sel, ALUop, OPCodeExtention};
  endfunction

  // IR-derived fields are unconstrained while fetching, so mask them.
  task automatic step(input string tag, input logic [17:0] exp,
                      input logic fetch);
    logic [17:0] m;
    m = fetch ? 18'h3FF00 : 18'h3FFFF;
    @(negedge clk);
    check(tag, 32'(obs() & m), 32'(exp & m));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ir, input int wf,
                           input int wm, input logic z, input logic n);
    ref_t r;
    logic [7:0] lo;
    r = ref_of(ir);
    lo = {r.imm, r.alu, ir[7:4]};
    flag_z = z;
    flag_n = n;
    for (int i = 0; i < wf; i++) begin
      mem_ack = 1'b0;
      instr = 16'($urandom);
      step("fetch_wait", {10'b1000000000, 8'h0}, 1'b1);
    end
    mem_ack = 1'b1;
    instr = ir;
    step("fetch_ack", {10'b1001100000, 8'h0}, 1'b1);
    mem_ack = 1'($urandom);
    instr = 16'($urandom);
    step("decode", {9'b0, r.kind == 3'd4, lo}, 1'b0);
    if (r.kind == 3'd0) begin
      mem_ack = 1'($urandom);
      step("exec_alu", {6'b0, r.rw, 1'b0, r.fl, 1'b0, lo}, 1'b0);
    end else if (r.kind == 3'd1) begin
      mem_ack = 1'($urandom);
      step("exec_br", {5'b0, taken(ir[11:8], z, n), 4'b0, lo}, 1'b0);
    end else if (r.kind == 3'd2 || r.kind == 3'd3) begin
      for (int i = 0; i <= wm; i++) begin
        mem_ack = (i == wm);
        step("mem", {1'b1, r.kind == 3'd3, 1'b1, 7'b0, lo}, 1'b0);
      end
      if (r.kind == 3'd2) begin
        mem_ack = 1'($urandom);
        step("wb", {6'b0, 2'b11, 2'b0, lo}, 1'b0);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] ir;
    logic [3:0]  op;
    reset_n = 1'b0;
    mem_ack = 1'b1;
    step("reset0", 18'h0, 1'b0);
    step("reset1", 18'h0, 1'b0);
    check("pc_init", 32'(pc_init), 32'h0);
    reset_n = 1'b1;
    mem_ack = 1'b0;

    run_instr(16'h5203, 0, 0, 1'b0, 1'b0);
    run_instr(16'h0251, 0, 0, 1'b1, 1'b0);
    run_instr(16'hB20A, 1, 0, 1'b0, 1'b1);
    run_instr(16'h4304, 0, 2, 1'b0, 1'b0);
    run_instr(16'h4345, 0, 0, 1'b0, 1'b0);
    run_instr(16'hC0FE, 0, 0, 1'b1, 1'b0);
    run_instr(16'hC0FE, 0, 0, 1'b0, 1'b0);
    run_instr(16'hCE02, 0, 0, 1'b0, 1'b0);
    run_instr(16'hF000, 0, 0, 1'b0, 1'b0);
    run_instr(16'h4344, 2, 0, 1'b0, 1'b0);

    // reset dropped while MEM waits on ack
    mem_ack = 1'b1;
    instr = 16'h4304;
    step("mr_fetch", {10'b1001100000, 8'h0}, 1'b1);
    mem_ack = 1'b0;
    step("mr_decode", {10'b0, 8'h00}, 1'b0);
    step("mr_mem", {10'b1010000000, 8'h00}, 1'b0);
    reset_n = 1'b0;
    step("mr_rst0", 18'h0, 1'b0);
    mem_ack = 1'b1;
    step("mr_rst1", 18'h0, 1'b0);
    reset_n = 1'b1;
    mem_ack = 1'b0;
    step("mr_refetch", {10'b1000000000, 8'h0}, 1'b1);
    run_instr(16'h1F0F, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      ir = 16'($urandom);
      op = ir[15:12];
      if (op == 4'h4 && $urandom_range(0, 3) != 0)
        ir[7:4] = ($urandom_range(0, 1) != 0) ? 4'h4 : 4'h0;
      if (op == 4'hC && $urandom_range(0, 1) != 0)
        ir[11:8] = ($urandom_range(0, 1) != 0) ? 4'hC : 4'hD;
      run_instr(ir, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
